// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_e       : FSM state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand width in bits
package serial_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_sub_cell.sv
// One-bit combinational full subtractor: computes a - b - bin.
// Ports:
//   a, b : operand bits
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff_o = a_i - b_i - borrow_in_i (mod 2^WIDTH), one bit
// per clock, LSB first, through a single full_sub_cell and a borrow register.
// An accepted start takes WIDTH RUN cycles followed by one DONE cycle (done_o).
// Ports:
//   clk_i       : clock, rising edge
//   rst_i       : synchronous active-high reset
//   start_i     : begin one subtraction (honoured only in IDLE)
//   a_i, b_i    : minuend / subtrahend, sampled with start_i
//   borrow_in_i : initial borrow, sampled with start_i
//   busy_o      : high in RUN and DONE
//   done_o      : one-cycle completion pulse
//   diff_o      : registered result, updated at the end of RUN
//   borrow_o    : registered final borrow
//   overflow_o  : signed overflow flag (only with SERIAL_SUBTRACTOR_OVERFLOW_EN)
// Optional feature macro: SERIAL_SUBTRACTOR_OVERFLOW_EN
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             borrow_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  ,
  output logic             overflow_o
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  state_e            r_state;
  state_e            w_state_next;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_diff;
  logic              r_borrow;
  logic              r_borrow_out;
  logic [CntW-1:0]   r_cnt;
  logic              w_d;
  logic              w_bout;
  logic              w_last;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic              r_overflow;
`endif

  full_sub_cell u_cell (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_last = (r_cnt == CntW'(WIDTH - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        busy_o = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        busy_o       = 1'b1;
        done_o       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_a          <= '0;
      r_b          <= '0;
      r_acc        <= '0;
      r_diff       <= '0;
      r_borrow     <= 1'b0;
      r_borrow_out <= 1'b0;
      r_cnt        <= '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      r_overflow   <= 1'b0;
`endif
    end else begin
      if (r_state == IDLE && start_i) begin
        r_a      <= a_i;
        r_b      <= b_i;
        r_borrow <= borrow_in_i;
        r_cnt    <= '0;
      end else if (r_state == RUN) begin
        r_a      <= r_a >> 1;
        r_b      <= r_b >> 1;
        r_acc    <= {w_d, r_acc[WIDTH-1:1]};
        r_borrow <= w_bout;
        r_cnt    <= r_cnt + CntW'(1);
        // Publish only on the MSB cycle so outputs hold the previous result
        // throughout the run.
        if (w_last) begin
          r_diff       <= {w_d, r_acc[WIDTH-1:1]};
          r_borrow_out <= w_bout;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
          // r_borrow is the borrow into the MSB, w_bout the borrow out of it.
          r_overflow   <= r_borrow ^ w_bout;
`endif
        end
      end
    end
  end

  assign diff_o   = r_diff;
  assign borrow_o = r_borrow_out;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  assign overflow_o = r_overflow;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH = 8).
// Inputs are driven and outputs sampled on the falling edge. The cycle in
// which start_i is high is cycle 0; done_o is expected in cycle WIDTH+1.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         borrow_in_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] diff_o;
  logic         borrow_o;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic         overflow_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] last_diff;

  always #5 clk_i = ~clk_i;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .borrow_in_i (borrow_in_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .diff_o      (diff_o),
    .borrow_o    (borrow_o)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    .overflow_o  (overflow_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full operation; optionally pulses a conflicting start in RUN cycle inj.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, input logic [W-1:0] exp_d, input logic exp_b,
                        input logic exp_v, input int inj);
    int   cyc;
    int   extra;
    logic hold_ok;
    logic busy_ok;
    @(negedge clk_i);
    a_i = a; b_i = b; borrow_in_i = bin; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    a_i = W'($urandom); b_i = W'($urandom); borrow_in_i = 1'($urandom);
    cyc = 1; hold_ok = 1'b1; busy_ok = 1'b1;
    while (!done_o && cyc <= 2 * W + 4) begin
      if (diff_o !== last_diff) hold_ok = 1'b0;
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      if (cyc == inj) begin
        start_i = 1'b1; a_i = 8'hFF; b_i = 8'h00; borrow_in_i = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk_i);
      cyc++;
    end
    start_i = 1'b0;
    check({tag, " done_cycle"}, cyc, W + 1);
    check({tag, " diff"}, diff_o, exp_d);
    check({tag, " borrow"}, borrow_o, exp_b);
    check({tag, " busy_in_done"}, busy_o, 1'b1);
    check({tag, " busy_in_run"}, busy_ok, 1'b1);
    check({tag, " diff_hold"}, hold_ok, 1'b1);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    check({tag, " overflow"}, overflow_o, exp_v);
`else
    if (exp_v) begin end
`endif
    extra = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk_i);
      if (done_o) extra++;
    end
    check({tag, " extra_done"}, extra, 0);
    check({tag, " idle_busy"}, busy_o, 1'b0);
    check({tag, " diff_after"}, diff_o, exp_d);
    last_diff = exp_d;
  endtask

  initial begin
    int seen;
    rst_i = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0; borrow_in_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    check("rst busy", busy_o, 1'b0);
    check("rst done", done_o, 1'b0);
    check("rst diff", diff_o, 8'h00);
    check("rst borrow", borrow_o, 1'b0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    check("rst overflow", overflow_o, 1'b0);
`endif
    last_diff = '0;

    run_op("unsigned", 8'd200, 8'd55, 1'b0, 8'd145, 1'b0, 1'b0, 0);
    run_op("underflow", 8'd5, 8'd10, 1'b0, 8'd251, 1'b1, 1'b0, 0);
    run_op("chain0", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
    run_op("chain1", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 0);
    run_op("ignored_start", 8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 3);
    run_op("ovf_neg", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0);

    // Abort in RUN cycle 4; start_i is held high on the reset edge as well.
    @(negedge clk_i);
    a_i = 8'd9; b_i = 8'd3; borrow_in_i = 1'b0; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1; start_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0; start_i = 1'b0;
    check("abort busy", busy_o, 1'b0);
    check("abort done", done_o, 1'b0);
    check("abort diff", diff_o, 8'h00);
    check("abort borrow", borrow_o, 1'b0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    check("abort overflow", overflow_o, 1'b0);
`endif
    seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk_i);
      if (done_o || busy_o) seen++;
    end
    check("abort no_done", seen, 0);
    last_diff = '0;

    run_op("after_abort", 8'd100, 8'd1, 1'b0, 8'd99, 1'b0, 1'b0, 0);
    run_op("ovf_none", 8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
